// File: rtl/reg_file_pkg.sv
// Shared CPU package: register-index constants and the helpers used by the
// register file, its scoreboard and the destination-select logic.
package reg_file_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef logic [AW-1:0] reg_idx_t;
    typedef logic [DW-1:0] word_t;

    localparam reg_idx_t ZERO = 5'd0;
    localparam reg_idx_t RA   = 5'd31;

    // A write only lands when it is enabled and does not target r0.
    function automatic logic real_write(input logic en, input reg_idx_t addr);
        return en && (addr != ZERO);
    endfunction

endpackage

// File: rtl/reg_file_if.sv
// Register file bus: two read ports, the write-back port and the decode-stage
// issue/stall handshake. Master is the pipeline, slave is reg_file.
interface reg_file_if;
    import reg_file_pkg::*;

    reg_idx_t rs;
    reg_idx_t rt;
    word_t    RD1;
    word_t    RD2;
    logic     reg_write;
    reg_idx_t write_addr;
    word_t    write_data;
    logic     issue_valid;
    logic     use_rs;
    logic     use_rt;
    logic     issue_we;
    reg_idx_t issue_dst;
    logic     stall;

    modport master (
        output rs, rt, reg_write, write_addr, write_data,
               issue_valid, use_rs, use_rt, issue_we, issue_dst,
        input  RD1, RD2, stall
    );

    modport slave (
        input  rs, rt, reg_write, write_addr, write_data,
               issue_valid, use_rs, use_rt, issue_we, issue_dst,
        output RD1, RD2, stall
    );

endinterface

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, set when
// a writing instruction issues and cleared by its write-back. Because a WAW
// hazard stalls issue, at most one write per register is ever in flight.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter bit BYPASS = 1'b1,
    parameter bit SB_EN  = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     issue_valid,
    input  logic     use_rs,
    input  logic     use_rt,
    input  reg_idx_t rs,
    input  reg_idx_t rt,
    input  logic     issue_we,
    input  reg_idx_t issue_dst,
    input  logic     wb_en,
    input  reg_idx_t wb_addr,
    output logic     haz_rs,
    output logic     haz_rt,
    output logic     haz_waw,
    output logic     stall
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic            wb_hit;
    logic            accept;

    assign wb_hit = real_write(wb_en, wb_addr);

    // Hazard detection; a write-back landing this cycle counts as ready only
    // when its value can be forwarded to the reader.
    always_comb begin
        haz_rs  = use_rs && busy[rs]
                  && !(BYPASS && wb_hit && (wb_addr == rs));
        haz_rt  = use_rt && busy[rt]
                  && !(BYPASS && wb_hit && (wb_addr == rt));
        haz_waw = issue_we && (issue_dst != ZERO) && busy[issue_dst]
                  && !(BYPASS && wb_hit && (wb_addr == issue_dst));
        stall   = SB_EN && issue_valid && (haz_rs || haz_rt || haz_waw);
    end

    // Per-register set/clear strobes; r0 never becomes busy.
    always_comb begin
        accept  = issue_valid && !stall && real_write(issue_we, issue_dst);
        set_vec = '0;
        clr_vec = '0;
        if (accept) set_vec[issue_dst] = 1'b1;
        if (wb_hit) clr_vec[wb_addr]   = 1'b1;
        set_vec[0] = 1'b0;
        clr_vec[0] = 1'b0;
    end

    // Busy vector update: set has priority over clear so a new producer issued
    // in the same cycle an older one retires stays tracked.
    always_ff @(posedge clk) begin
        if (reset || !SB_EN) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (set_vec[i])      busy[i] <= 1'b1;
                else if (clr_vec[i]) busy[i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// 32 x 32 register file with combinational reads, optional write-to-read
// forwarding and an optional pending-write scoreboard driving decode stall.
module reg_file
    import reg_file_pkg::*;
#(
    parameter bit BYPASS = 1'b1,
    parameter bit SB_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    reg_file_if.slave  bus
);

    word_t regs [NREG];
    logic  wb_hit;
    logic  haz_rs;
    logic  haz_rt;
    logic  haz_waw;

    assign wb_hit = real_write(bus.reg_write, bus.write_addr);

    // Storage: r0 is never written so it stays at its reset value of zero;
    // a write presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_hit) begin
            regs[bus.write_addr] <= bus.write_data;
        end
    end

    // Read ports, with same-cycle forwarding of the write-back value.
    always_comb begin
        bus.RD1 = regs[bus.rs];
        bus.RD2 = regs[bus.rt];
        if (BYPASS && wb_hit && (bus.write_addr == bus.rs)) bus.RD1 = bus.write_data;
        if (BYPASS && wb_hit && (bus.write_addr == bus.rt)) bus.RD2 = bus.write_data;
        if (bus.rs == ZERO) bus.RD1 = '0;
        if (bus.rt == ZERO) bus.RD2 = '0;
    end

    reg_scoreboard #(
        .BYPASS (BYPASS),
        .SB_EN  (SB_EN)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (bus.issue_valid),
        .use_rs      (bus.use_rs),
        .use_rt      (bus.use_rt),
        .rs          (bus.rs),
        .rt          (bus.rt),
        .issue_we    (bus.issue_we),
        .issue_dst   (bus.issue_dst),
        .wb_en       (bus.reg_write),
        .wb_addr     (bus.write_addr),
        .haz_rs      (haz_rs),
        .haz_rt      (haz_rt),
        .haz_waw     (haz_waw),
        .stall       (bus.stall)
    );

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter BYPASS, default 1, enabling write-to-read same-cycle forwarding.
REQ-002 SHALL have parameter SB_EN, default 1, enabling the pending-write scoreboard; when 0, stall is tied to 0.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rs  input  5  read address, port 1.
REQ-006 rt  input  5  read address, port 2.
REQ-007 RD1  output  32  read data, port 1.
REQ-008 RD2  output  32  read data, port 2.
REQ-009 reg_write  input  1  write-back enable.
REQ-010 write_addr  input  5  write-back destination, from the destination-select stage.
REQ-011 write_data  input  32  write-back value, from the write-back data-select stage.
REQ-012 issue_valid  input  1  decode stage presents an instruction.
REQ-013 use_rs  input  1  the issuing instruction reads rs.
REQ-014 use_rt  input  1  the issuing instruction reads rt.
REQ-015 issue_we  input  1  the issuing instruction will write a register.
REQ-016 issue_dst  input  5  the issuing instruction's destination (rt, rd or 31).
REQ-017 stall  output  1  the issuing instruction must hold in decode this cycle.

Function
REQ-018 Storage SHALL be 32 x 32-bit registers; register 0 SHALL read 0 and ignore writes.
REQ-019 Reads SHALL be combinational (zero latency) from rs/rt.
REQ-020 With BYPASS=1, when reg_write=1, write_addr!=0 and write_addr equals a read address, that port SHALL return write_data in the same cycle.
REQ-021 With BYPASS=0, a same-cycle read SHALL return the old value; the new value SHALL be visible on the next cycle.
REQ-022 A write SHALL commit on the clock edge when reg_write=1 and write_addr!=0.
REQ-023 The scoreboard SHALL hold busy[31:1], with busy[0] always 0.
REQ-024 A hazard on rs SHALL exist when use_rs=1 and busy[rs]=1, unless the same cycle's write-back targets rs (cleared-this-cycle counts as ready when BYPASS=1; with BYPASS=0 it SHALL stall).
REQ-025 A hazard on rt SHALL follow the same rule with use_rt/rt.
REQ-026 A WAW hazard SHALL exist when issue_we=1, issue_dst!=0 and busy[issue_dst]=1, with the same write-back exemption as REQ-024.
REQ-027 stall SHALL equal issue_valid AND (rs, rt or WAW hazard); it SHALL be purely combinational.
REQ-028 An accepted issue (issue_valid=1, stall=0, issue_we=1, issue_dst!=0) SHALL set busy[issue_dst] on the clock edge.
REQ-029 A write-back (reg_write=1, write_addr!=0) SHALL clear busy[write_addr] on the clock edge.
REQ-030 When set and clear target the same register in one cycle, the set SHALL win.
REQ-031 Given REQ-026, at most one write per register SHALL be outstanding; no counters are needed.
REQ-032 A write-back to a non-busy register SHALL update storage and leave busy unchanged.

Reset
REQ-033 On reset=1 at a clock edge, all registers and all busy bits SHALL clear to 0; RD1/RD2 SHALL then read 0.
REQ-034 A write-back or issue presented in the reset cycle SHALL be discarded.
REQ-035 While reset=1, stall SHALL still be computed combinationally from the current (pre-reset) busy state.

Structure
REQ-036 Register-index constants (ZERO=0, RA=31) and NREG=32 SHALL live in the shared CPU package, shared with the destination-select logic.
REQ-037 The scoreboard SHALL be one sub-module, reg_scoreboard (busy vector, set/clear, hazard outputs); storage and bypass SHALL stay in reg_file.

Verification
REQ-038 Reset, then write 0xDEADBEEF to r5; next cycle rs=5 -> RD1=0xDEADBEEF.
REQ-039 BYPASS=1: reg_write=1, write_addr=7, write_data=0x12345678, rt=7 in the same cycle -> RD2=0x12345678 in that cycle; BYPASS=0 -> old value.
REQ-040 Write 0xFFFFFFFF to r0 -> RD1 with rs=0 stays 0, and no busy bit is set for issue_dst=0.
REQ-041 Issue with issue_dst=9; next instruction with use_rs=1, rs=9 -> stall=1 until the cycle write_addr=9 write-back occurs, then stall=0 (BYPASS=1) and RD1=write_data.
REQ-042 Issue with issue_dst=31 (jal) while write-back to r31 clears an older producer in the same cycle -> busy[31]=1 afterwards; a second issue to r31 stalls.
REQ-043 Set busy[3], then assert reset -> busy cleared, and an rs=3 reader is not stalled on the next cycle.
